gf2m59_reduce_seq: RTL and testbench
====================================

Name: gf2m59_reduce_seq

Overview:
- Sequential modular-reduction stage placed directly downstream of the 59-bit combinational Karatsuba GF(2)[x] multiplier.
- Accepts the 117-bit carry-less product and reduces it modulo the field polynomial p(x) = x^59 + r(x), giving a 59-bit GF(2^59) element.
- Reduction folds DIGIT high bits per clock under a valid/ready handshake, trading area for latency.

Parameters:
- M, 59, field degree; output width.
- PROD_W, 117, product width (2*M-1).
- POLY_R, 59'h95, low part r(x) of p(x); default is x^7+x^4+x^2+1.
- R_DEG, 7, degree of r(x).
- DIGIT, 2, high bits folded per cycle.
  - Legal values: 1, 2 and 29 (divisors of M-1 = 58).
  - DIGIT+R_DEG <= M is also required.
  - Any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  product available
- in_ready  out  1  block can accept a product
- in_prod  in  PROD_W  unreduced product c(x), bit i = coeff of x^i
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_res  out  M  c(x) mod p(x)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1; out_valid=0; out_res=0.
  - Working register cleared to 0; digit counter cleared to 0.
  - Asserting rst mid-FOLD or in DONE aborts the operation. The partial result is discarded and never presented.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1, the working register W[116:0] loads in_prod, the counter loads NFOLD=(M-1)/DIGIT, and the state moves to FOLD.
- State FOLD:
  - in_ready=0, out_valid=0.
  - Each edge processes the top DIGIT unresolved positions p = 58+cnt*DIGIT down to p-DIGIT+1.
  - For each set bit W[p]: W[p] is cleared and r(x)<<(p-59) is XORed into W.
  - All DIGIT bits of one step are folded in the same cycle.
  - DIGIT+R_DEG <= M guarantees a fold never lands inside the digit being processed.
  - The counter decrements every edge. On the edge where cnt goes 1->0, W[58:0] (already fully reduced) is written into out_res and the state moves to DONE.
- State DONE:
  - out_valid=1; out_res stays stable until the handshake completes.
  - On an edge with out_ready=1 the state moves to IDLE and out_valid drops.
  - in_ready stays 0 throughout DONE, so accept and deliver never overlap.
- Latency:
  - Accept edge E; out_valid is high after edge E+NFOLD.
  - NFOLD = 58, 29 or 2 for DIGIT = 1, 2 or 29.
  - Minimum initiation interval is NFOLD+2 cycles when out_ready is held high.
- Arithmetic: all operations are XOR only; there are no carries. out_res depends only on in_prod, never on timing.
- Boundary cases:
  - in_prod < 2^59 passes through unchanged, after the same latency.
  - in_prod = 0 gives 0.
  - in_valid held high in FOLD/DONE is ignored.
  - out_ready asserted outside DONE has no effect.
  - in_prod is sampled only on the accept edge; changes after that edge do not affect the result.

Decomposition:
- Package gf2m59_pkg holds:
  - constants M, PROD_W, POLY_R, R_DEG;
  - state enum {IDLE, FOLD, DONE};
  - a function that returns NFOLD for a given DIGIT.
- One natural sub-module, gf2m_fold_digit (combinational):
  - inputs W and the digit position;
  - output is W with that DIGIT-bit window cleared and the r(x) contributions XORed in.
  - The top level instantiates it once, plus the FSM, counter and registers.

Test Plan:
- Reset, then in_prod = 117'h0 -> exactly 29 cycles after accept (DIGIT=2) out_valid=1, out_res=0, in_ready=0 until consumed.
- in_prod = 1<<59 -> out_res = 59'h95.
- in_prod = 1<<116 -> out_res = 59'h200_0000_0000_1061 (x^57+x^12+x^6+x^5+1).
- in_prod = 59'h7FF_FFFF_FFFF_FFFF (no high bits) -> out_res identical; hold out_ready=0 for 10 cycles -> out_valid and out_res stay constant and in_ready stays 0; then out_ready=1 -> IDLE next edge.
- Assert rst at cycle 10 of FOLD with in_prod = 1<<116 -> out_valid=0, in_ready=1 immediately (async). The next operation with in_prod = 1<<59 returns 59'h95 with no residue from the aborted one.
- 1000 random in_prod back-to-back, out_ready randomly throttled, DIGIT in {1, 2, 29} -> every out_res matches a bitwise polynomial-mod reference model, and results come out in input order.

Source files
------------

// File: rtl/gf2m59_pkg.sv
// Shared constants and types for the GF(2^59) sequential reduction stage.
// Field polynomial is p(x) = x^59 + r(x), with r(x) = x^7 + x^4 + x^2 + 1.
package gf2m59_pkg;

   localparam int             M      = 59;
   localparam int             PROD_W = 2 * M - 1;
   localparam logic [M-1:0]   POLY_R = 59'h95;
   localparam int             R_DEG  = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FOLD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of fold steps needed to clear positions 116..59.
   function automatic int nfold(input int digit);
      return (M - 1) / digit;
   endfunction

endpackage

// File: rtl/gf2m_fold_digit.sv
// Folds one DIGIT-wide window of high coefficients of w back into the low part.
// Every bit in the window is folded in the same cycle.
module gf2m_fold_digit
   import gf2m59_pkg::*;
#(
   parameter int DIGIT = 2
) (
   input  logic [PROD_W-1:0] w,
   input  logic [6:0]        pos,
   output logic [PROD_W-1:0] w_next
);

   localparam logic [PROD_W-1:0] R_EXT = PROD_W'(POLY_R);

   logic [6:0] bit_pos;

   // The reduced image of x^p lies entirely below the window, so all
   // window bits can be tested against the unmodified w.
   always_comb begin
      w_next  = w;
      bit_pos = pos;
      for (int i = 0; i < DIGIT; i++) begin
         bit_pos = pos - 7'(i);
         if (w[bit_pos]) begin
            w_next[bit_pos] = 1'b0;
            w_next          = w_next ^ (R_EXT << (bit_pos - 7'(M)));
         end
      end
   end

endmodule

// File: rtl/gf2m59_reduce_seq.sv
// Sequential reduction of a 117-bit carry-less product modulo x^59 + r(x).
// Processes DIGIT high coefficients per clock under a valid/ready handshake.
module gf2m59_reduce_seq
   import gf2m59_pkg::*;
#(
   parameter int DIGIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [M-1:0]      out_res
);

   localparam int NFOLD = nfold(DIGIT);
   localparam int CNT_W = 6;

   generate
      if (!((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 29)) || (DIGIT + R_DEG > M)) begin : g_bad_digit
         $error("gf2m59_reduce_seq: DIGIT must be 1, 2 or 29 with DIGIT+R_DEG <= M");
      end
   endgenerate

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [PROD_W-1:0]  w;
   logic [PROD_W-1:0]  w_fold;
   logic [6:0]         pos;

   // Top coefficient of the current window: 58 + cnt*DIGIT.
   assign pos = 7'(M - 1) + 7'(cnt) * 7'(DIGIT);

   gf2m_fold_digit #(
      .DIGIT (DIGIT)
   ) u_fold (
      .w      (w),
      .pos    (pos),
      .w_next (w_fold)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = FOLD;
         end
         FOLD: begin
            if (cnt == CNT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w       <= '0;
         cnt     <= '0;
         out_res <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  w   <= in_prod;
                  cnt <= CNT_W'(NFOLD);
               end
            end
            FOLD: begin
               w   <= w_fold;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) out_res <= w_fold[M-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2m59_reduce_seq.sv
// Bench for gf2m59_reduce_seq: directed vectors, handshake corner cases and
// randomized traffic on DIGIT = 1, 2 and 29 against a polynomial-division model.
module tb_gf2m59_reduce_seq;

   localparam int NI = 3;

   function automatic int dig(input int k);
      case (k)
         0:       return 1;
         1:       return 2;
         default: return 29;
      endcase
   endfunction

   function automatic int nf(input int k);
      return 58 / dig(k);
   endfunction

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid  [NI];
   logic          out_ready [NI];
   logic [116:0]  in_prod   [NI];
   wire           in_ready  [NI];
   wire           out_valid [NI];
   wire  [58:0]   out_res   [NI];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      gf2m59_reduce_seq #(
         .DIGIT (dig(k))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_prod   (in_prod[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_res   (out_res[k])
      );
   end

   int nvec = 0;
   int nerr = 0;
   logic [58:0] expq [$];

   // Reference: long division by p(x) = x^59 + x^7 + x^4 + x^2 + 1.
   function automatic logic [58:0] ref_mod(input logic [116:0] c);
      logic [116:0] p;
      p = (117'(1) << 59) | 117'h95;
      for (int i = 116; i >= 59; i--)
         if (c[i]) c = c ^ (p << (i - 59));
      return c[58:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_one(input int k, input logic [116:0] prod, input logic [58:0] exp,
                          input string name, input bit hold_valid, input int stall);
      int cyc;
      check({name, "_ready_pre"}, 128'(in_ready[k]), 128'(1));
      in_valid[k] = 1'b1;
      in_prod[k]  = prod;
      step();
      if (!hold_valid) in_valid[k] = 1'b0;
      in_prod[k] = ~prod;
      cyc = 0;
      while (!out_valid[k] && cyc < 200) begin
         step();
         cyc++;
      end
      check({name, "_latency"}, 128'(cyc), 128'(nf(k)));
      check({name, "_res"}, 128'(out_res[k]), 128'(exp));
      check({name, "_ready_busy"}, 128'(in_ready[k]), 128'(0));
      for (int s = 0; s < stall; s++) begin
         step();
         check({name, "_hold_valid"}, 128'(out_valid[k]), 128'(1));
         check({name, "_hold_res"}, 128'(out_res[k]), 128'(exp));
         check({name, "_hold_ready"}, 128'(in_ready[k]), 128'(0));
      end
      out_ready[k] = 1'b1;
      step();
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b0;
      check({name, "_valid_drop"}, 128'(out_valid[k]), 128'(0));
      check({name, "_ready_back"}, 128'(in_ready[k]), 128'(1));
   endtask

   function automatic logic [116:0] rand_prod();
      logic [127:0] rr;
      rr = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rr = rr & ((128'(1) << 59) - 128'(1));
      return rr[116:0];
   endfunction

   task automatic rand_run(input int k, input int n);
      expq.delete();
      fork
         begin : drive
            logic [116:0] prod;
            bit           accepted;
            bit           ready_now;
            int           wt;
            for (int t = 0; t < n; t++) begin
               prod        = rand_prod();
               in_valid[k] = 1'b1;
               in_prod[k]  = prod;
               accepted    = 1'b0;
               wt          = 0;
               while (!accepted && wt < 300) begin
                  ready_now = in_ready[k];
                  step();
                  wt++;
                  if (ready_now) accepted = 1'b1;
               end
               if (!accepted) begin
                  check("rand_accept_timeout", 128'(accepted), 128'(1));
                  break;
               end
               expq.push_back(ref_mod(prod));
               in_valid[k] = 1'b0;
               in_prod[k]  = rand_prod();
               if ($urandom_range(0, 3) == 0) step();
            end
            in_valid[k] = 1'b0;
         end
         begin : monitor
            int got;
            int idle;
            got  = 0;
            idle = 0;
            while (got < n && idle < 400) begin
               out_ready[k] = ($urandom_range(0, 3) != 0);
               if (out_valid[k] && out_ready[k]) begin
                  if (expq.size() == 0) begin
                     check("rand_unexpected", 128'(out_res[k]), 128'(0));
                     nerr += (out_res[k] == 59'd0) ? 1 : 0;
                  end else begin
                     check($sformatf("rand_res_d%0d", dig(k)), 128'(out_res[k]), 128'(expq.pop_front()));
                  end
                  got++;
                  idle = 0;
               end
               step();
               idle++;
            end
            check($sformatf("rand_count_d%0d", dig(k)), 128'(got), 128'(n));
            out_ready[k] = 1'b0;
         end
      join
   endtask

   typedef struct {
      logic [116:0] prod;
      logic [58:0]  exp;
      bit           hold;
      int           stall;
   } vec_t;

   vec_t tbl [6];

   initial begin
      for (int k = 0; k < NI; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         in_prod[k]   = '0;
      end
      tbl[0] = '{117'h0,                 59'h0,                  1'b0, 0};
      tbl[1] = '{117'(1) << 59,          59'h95,                 1'b0, 0};
      tbl[2] = '{117'(1) << 116,         59'h200_0000_0000_1061, 1'b1, 0};
      tbl[3] = '{117'h7FF_FFFF_FFFF_FFFF, 59'h7FF_FFFF_FFFF_FFFF, 1'b0, 10};
      tbl[4] = '{117'(1) << 60,          59'h12A,                1'b1, 2};
      tbl[5] = '{(117'(1) << 59) | 117'h1, 59'h94,               1'b0, 0};

      #12;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset_in_ready%0d", k), 128'(in_ready[k]), 128'(1));
         check($sformatf("reset_out_valid%0d", k), 128'(out_valid[k]), 128'(0));
         check($sformatf("reset_out_res%0d", k), 128'(out_res[k]), 128'(0));
      end
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++)
         run_one(1, tbl[i].prod, tbl[i].exp, $sformatf("vec%0d", i), tbl[i].hold, tbl[i].stall);

      // Abort mid-FOLD: reset takes effect without a clock edge.
      in_valid[1] = 1'b1;
      in_prod[1]  = 117'(1) << 116;
      step();
      in_valid[1] = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      #1;
      check("abort_out_valid", 128'(out_valid[1]), 128'(0));
      check("abort_in_ready", 128'(in_ready[1]), 128'(1));
      check("abort_out_res", 128'(out_res[1]), 128'(0));
      step();
      rst = 1'b0;
      step();
      run_one(1, 117'(1) << 59, 59'h95, "after_abort", 1'b0, 0);

      for (int k = 0; k < NI; k++)
         run_one(k, 117'(1) << 116, 59'h200_0000_0000_1061, $sformatf("top_bit_d%0d", dig(k)), 1'b0, 1);

      rand_run(1, 1000);
      rand_run(0, 200);
      rand_run(2, 400);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
